// File: rtl/tl_pkg.sv
// Shared transaction-layer definitions: state encodings, word layout and class extraction.
package tl_pkg;

  localparam int DATA_W    = 12;
  localparam int CLASS_LSB = 8;

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_INIT   = 2'd1,
    ST_IDLE   = 2'd2,
    ST_ACTIVE = 2'd3
  } estado_t;

  function automatic logic [1:0] clase_de(input logic [DATA_W-1:0] d);
    return d[CLASS_LSB+1 -: 2];
  endfunction

endpackage

// File: rtl/arbitro_tl_prioridad_fija.sv
// Fixed-priority one-hot encoder over four requests, lowest index wins.
module prioridad_fija (
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic       any
);

  always_comb begin
    gnt = 4'b0000;
    if (req[0])      gnt = 4'b0001;
    else if (req[1]) gnt = 4'b0010;
    else if (req[2]) gnt = 4'b0100;
    else if (req[3]) gnt = 4'b1000;
  end

  assign any = |req;

endmodule

// File: rtl/arbitro_tl.sv
// Transaction-layer arbiter: moves one word per cycle from the input VC FIFOs to the
// output FIFO chosen by the word's class, and owns the shared FIFO thresholds.
module arbitro_tl #(
  parameter int DATA_W    = tl_pkg::DATA_W,
  parameter int CLASS_LSB = tl_pkg::CLASS_LSB,
  parameter int CNT_W     = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init,
  input  logic [2:0]        Umbral_bajo_in,
  input  logic [2:0]        Umbral_alto_in,
  input  logic [DATA_W-1:0] data_in0,
  input  logic [DATA_W-1:0] data_in1,
  input  logic [DATA_W-1:0] data_in2,
  input  logic [DATA_W-1:0] data_in3,
  input  logic [3:0]        empty_in,
  input  logic [3:0]        almost_full_out,
  output logic [3:0]        pop_in,
  output logic [3:0]        push_out,
  output logic [DATA_W-1:0] data_out,
  output logic [2:0]        Umbral_bajo,
  output logic [2:0]        Umbral_alto,
  output logic              idle,
  output logic [1:0]        estado,
  output logic [CNT_W-1:0]  contador0,
  output logic [CNT_W-1:0]  contador1,
  output logic [CNT_W-1:0]  contador2,
  output logic [CNT_W-1:0]  contador3
);

  import tl_pkg::*;

  estado_t           state;
  logic [DATA_W-1:0] head [4];
  logic [1:0]        clase [4];
  logic [3:0]        elegible;
  logic [3:0]        gnt;
  logic              hay_gnt;
  logic              pop_valid;
  logic [DATA_W-1:0] sel_data;
  logic [1:0]        sel_clase;
  logic [CNT_W-1:0]  cnt [4];

  assign head[0] = data_in0;
  assign head[1] = data_in1;
  assign head[2] = data_in2;
  assign head[3] = data_in3;

  // A blocked head word is skipped so it cannot starve lower-priority channels.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      clase[i]    = head[i][CLASS_LSB+1 -: 2];
      elegible[i] = !empty_in[i] && !almost_full_out[clase[i]];
    end
  end

  prioridad_fija u_prioridad (
    .req (elegible),
    .gnt (gnt),
    .any (hay_gnt)
  );

  assign pop_valid = reset && (state == ST_ACTIVE) && !init && hay_gnt;
  assign pop_in    = pop_valid ? gnt : 4'b0000;

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < 4; i++) begin
      if (gnt[i]) sel_data = head[i];
    end
  end

  assign sel_clase = sel_data[CLASS_LSB+1 -: 2];

  // The word popped this cycle is pushed next cycle even if init stops further pops.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= ST_RESET;
      push_out    <= 4'b0000;
      data_out    <= '0;
      Umbral_bajo <= 3'd0;
      Umbral_alto <= 3'd0;
      for (int j = 0; j < 4; j++) cnt[j] <= '0;
    end else begin
      push_out <= 4'b0000;
      if (pop_valid) begin
        push_out         <= 4'b0001 << sel_clase;
        data_out         <= sel_data;
        cnt[sel_clase]   <= cnt[sel_clase] + CNT_W'(1);
      end
      case (state)
        ST_RESET:  state <= init ? ST_INIT : ST_IDLE;
        ST_INIT: begin
          Umbral_bajo <= Umbral_bajo_in;
          Umbral_alto <= Umbral_alto_in;
          if (!init) state <= ST_IDLE;
        end
        ST_IDLE: begin
          if (init)                state <= ST_INIT;
          else if (!(&empty_in))   state <= ST_ACTIVE;
        end
        ST_ACTIVE: begin
          if (init)                                   state <= ST_INIT;
          else if ((&empty_in) && (push_out == 4'b0)) state <= ST_IDLE;
        end
        default: state <= ST_RESET;
      endcase
    end
  end

  assign estado    = state;
  assign idle      = (state == ST_IDLE);
  assign contador0 = cnt[0];
  assign contador1 = cnt[1];
  assign contador2 = cnt[2];
  assign contador3 = cnt[3];

endmodule

// File: tb/tb_arbitro_tl.sv
// Directed bench for arbitro_tl: reset/init, routing, priority, fill, init and reset mid-stream.
module tb_arbitro_tl;

  logic        clk = 1'b0;
  logic        reset, init;
  logic [2:0]  Umbral_bajo_in, Umbral_alto_in;
  logic [11:0] data_in0, data_in1, data_in2, data_in3;
  logic [3:0]  empty_in, almost_full_out;
  logic [3:0]  pop_in, push_out;
  logic [11:0] data_out;
  logic [2:0]  Umbral_bajo, Umbral_alto;
  logic        idle;
  logic [1:0]  estado;
  logic [4:0]  contador0, contador1, contador2, contador3;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  arbitro_tl dut (
    .clk(clk), .reset(reset), .init(init),
    .Umbral_bajo_in(Umbral_bajo_in), .Umbral_alto_in(Umbral_alto_in),
    .data_in0(data_in0), .data_in1(data_in1), .data_in2(data_in2), .data_in3(data_in3),
    .empty_in(empty_in), .almost_full_out(almost_full_out),
    .pop_in(pop_in), .push_out(push_out), .data_out(data_out),
    .Umbral_bajo(Umbral_bajo), .Umbral_alto(Umbral_alto),
    .idle(idle), .estado(estado),
    .contador0(contador0), .contador1(contador1), .contador2(contador2), .contador3(contador3)
  );

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  logic [11:0] words [4];
  int          k;
  int          occ;

  initial begin
    reset = 1'b0; init = 1'b0;
    Umbral_bajo_in = 3'd0; Umbral_alto_in = 3'd0;
    data_in0 = '0; data_in1 = '0; data_in2 = '0; data_in3 = '0;
    empty_in = 4'hF; almost_full_out = 4'h0;

    tick();
    check_output("rst_estado", estado, 0);
    check_output("rst_push", push_out, 0);
    check_output("rst_data", data_out, 0);
    check_output("rst_thr", {Umbral_bajo, Umbral_alto}, 0);
    check_output("rst_idle", idle, 0);

    // Reset release with init, program 0/7 then 1/6
    reset = 1'b1; init = 1'b1; Umbral_bajo_in = 3'd0; Umbral_alto_in = 3'd7;
    tick();
    check_output("init_estado", estado, 1);
    check_output("init_pop", pop_in, 0);
    tick();
    check_output("init_thr_a", {Umbral_bajo, Umbral_alto}, {3'd0, 3'd7});
    Umbral_bajo_in = 3'd1; Umbral_alto_in = 3'd6;
    tick();
    check_output("init_thr_b", {Umbral_bajo, Umbral_alto}, {3'd1, 3'd6});
    init = 1'b0;
    tick();
    check_output("idle_estado", estado, 2);
    check_output("idle_flag", idle, 1);
    check_output("idle_thr", {Umbral_bajo, Umbral_alto}, {3'd1, 3'd6});
    check_output("idle_push", push_out, 0);

    // Routing: one word per class from input 0
    words[0] = 12'h001; words[1] = 12'h101; words[2] = 12'h201; words[3] = 12'h301;
    data_in0 = words[0]; empty_in = 4'b1110;
    settle();
    check_output("idle_nopop", pop_in, 0);
    tick();
    check_output("act_estado", estado, 3);
    for (int w = 0; w < 4; w++) begin
      data_in0 = words[w];
      settle();
      check_output("route_pop", pop_in, 4'b0001);
      tick();
      check_output("route_push", push_out, 4'b0001 << tl_pkg::clase_de(words[w]));
      check_output("route_data", data_out, words[w]);
    end
    empty_in = 4'hF;
    settle();
    check_output("drain_pop", pop_in, 0);
    tick();
    check_output("drain_push", push_out, 0);
    check_output("drain_still_act", estado, 3);
    tick();
    check_output("drain_idle", estado, 2);
    check_output("route_cnts", {contador0, contador1, contador2, contador3},
                 {5'd1, 5'd1, 5'd1, 5'd1});

    // Priority and skipping
    data_in0 = 12'h101; data_in2 = 12'h001; empty_in = 4'b1010; almost_full_out = 4'b0010;
    tick();
    settle();
    check_output("skip_pop", pop_in, 4'b0100);
    tick();
    check_output("skip_push", push_out, 4'b0001);
    check_output("skip_data", data_out, 12'h001);
    almost_full_out = 4'b0000;
    settle();
    check_output("prio_pop", pop_in, 4'b0001);
    tick();
    check_output("prio_push", push_out, 4'b0010);
    check_output("prio_data", data_out, 12'h101);
    empty_in = 4'b1011;
    settle();
    check_output("low_pop", pop_in, 4'b0100);
    tick();
    check_output("low_push", push_out, 4'b0001);
    check_output("prio_cnts", {contador0, contador1}, {5'd3, 5'd2});
    empty_in = 4'hF;
    tick();
    tick();
    check_output("prio_idle", estado, 2);

    // Fill output 2 up to almost-full (threshold 6, no drain)
    k = 0; occ = 0;
    data_in0 = 12'h200; empty_in = 4'b1110;
    tick();
    for (int c = 0; c < 10; c++) begin
      almost_full_out = (occ >= 6) ? 4'b0100 : 4'b0000;
      data_in0 = 12'h200 + 12'(k);
      empty_in = (k >= 8) ? 4'b1111 : 4'b1110;
      settle();
      if (occ >= 6) check_output("fill_blocked_pop", pop_in, 0);
      if (pop_in == 4'b0001) k++;
      tick();
      if (push_out[2]) occ++;
    end
    check_output("fill_pops", k, 6);
    check_output("fill_pushes", occ, 6);
    check_output("fill_cnt2", contador2, 7);
    check_output("fill_last", data_out, 12'h205);
    check_output("fill_estado", estado, 3);

    // Resume, then init mid-stream
    almost_full_out = 4'b0000; data_in0 = 12'h206; empty_in = 4'b1110;
    settle();
    check_output("resume_pop", pop_in, 4'b0001);
    tick();
    init = 1'b1; Umbral_bajo_in = 3'd2; Umbral_alto_in = 3'd5; data_in0 = 12'h207;
    settle();
    check_output("midinit_pop", pop_in, 0);
    check_output("midinit_push", push_out, 4'b0100);
    check_output("midinit_data", data_out, 12'h206);
    tick();
    check_output("midinit_estado", estado, 1);
    check_output("midinit_nopush", push_out, 0);
    check_output("midinit_cnt2", contador2, 8);
    tick();
    check_output("midinit_thr", {Umbral_bajo, Umbral_alto}, {3'd2, 3'd5});
    init = 1'b0;
    tick();
    check_output("reinit_idle", estado, 2);
    tick();
    settle();
    check_output("reinit_pop", pop_in, 4'b0001);
    tick();
    check_output("reinit_push", push_out, 4'b0100);
    check_output("reinit_data", data_out, 12'h207);
    check_output("reinit_cnt2", contador2, 9);

    // Reset in the middle of back-to-back pushes
    data_in0 = 12'h301;
    tick();
    check_output("pre_rst_push", push_out, 4'b1000);
    check_output("pre_rst_cnt3", contador3, 2);
    reset = 1'b0;
    tick();
    check_output("mid_rst_estado", estado, 0);
    check_output("mid_rst_push", push_out, 0);
    check_output("mid_rst_data", data_out, 0);
    check_output("mid_rst_thr", {Umbral_bajo, Umbral_alto}, 0);
    check_output("mid_rst_cnts", {contador0, contador1, contador2, contador3}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/arbitro_tl.md
# arbitro_tl

Arbiter and sequencer between the four input virtual-channel FIFOs and the four output FIFOs of the transaction layer. It holds the shared almost-full/almost-empty thresholds, which are programmed during INIT. It moves one 12-bit word per cycle from the highest-priority eligible input FIFO to the output FIFO named by the word's class field, and it reports idle status and per-output push counts.

## Interface
Parameters:
- DATA_W, 12, word width
- CLASS_LSB, 8, LSB of the 2-bit destination class field; class = data[CLASS_LSB+1:CLASS_LSB]
- CNT_W, 5, width of the per-output push counters

Ports:
- clk  in  1  single clock; all logic on the rising edge
- reset  in  1  synchronous, active-low; one clock, no other clock domains
- init  in  1  configuration request
- Umbral_bajo_in  in  3  almost-empty threshold to program
- Umbral_alto_in  in  3  almost-full threshold to program
- data_in0..data_in3  in  DATA_W  head word of input FIFO i (first-word fall-through)
- empty_in  in  4  input FIFO i empty
- almost_full_out  in  4  output FIFO j almost full
- pop_in  out  4  pop strobe to input FIFO i, combinational, one-hot or zero
- push_out  out  4  push strobe to output FIFO j, registered, one-hot or zero
- data_out  out  DATA_W  word for output FIFOs, registered
- Umbral_bajo, Umbral_alto  out  3  programmed thresholds, driven to all FIFOs
- idle  out  1  high in IDLE
- estado  out  2  current state
- contador0..contador3  out  CNT_W  words pushed to output j since reset

## Operation
- States: RESET=0, INIT=1, IDLE=2, ACTIVE=3.
- reset low at a rising edge: state goes to RESET, and every output and register clears to 0, including thresholds, counters and the in-flight push.
- RESET: on the first edge with reset high, go to INIT if init=1, else go to IDLE.
- INIT: Umbral_bajo/Umbral_alto load from the inputs on every edge. No pops are issued. When init=0, go to IDLE.
- IDLE: idle=1, no pops. Go to INIT if init=1. Otherwise go to ACTIVE if any empty_in bit is 0.
- ACTIVE: input i is eligible when empty_in[i]=0 and almost_full_out[class(data_in_i)]=0. Fixed priority applies, lowest index first. pop_in asserts for the winner only.
  - An ineligible input is skipped; it does not block lower-priority inputs.
  - If no input is eligible, no pop occurs and the state stays ACTIVE.
- ACTIVE exits:
  - init=1: go to INIT. Pops stop that same cycle; an in-flight push still completes.
  - All empty_in=1 and no push in flight: go to IDLE.
- Counters: contador_j increments on each push_out[j] and wraps 31→0.

## Timing
- A pop at cycle t produces push_out[class] and data_out at cycle t+1; latency is 1. The word is unmodified.
- Throughput is 1 word/cycle. pop_in never has two bits set.
- almost_full_out is sampled in the pop cycle. Because of the one-word in-flight slack, output FIFO depth must be at least Umbral_alto+2.
- Thresholds update 1 cycle after an INIT edge and hold outside INIT.
- Simultaneous events: reset low overrides everything. init=1 in ACTIVE overrides arbitration.

## Structure
- Shared package `tl_pkg` holds the state encodings, DATA_W, CLASS_LSB and the class-extraction function; the FIFOs and bench reuse them.
- One sub-module, `prioridad_fija`: a 4-bit fixed-priority one-hot encoder with an any-grant flag.

## Test plan
- **Reset and init:** reset=0 for 1 cycle, then reset=1 with init=1; program 0/7, then 1/6, then init=0 → estado goes 0→1→2, Umbral_bajo=1 and Umbral_alto=6, all strobes stay 0.
- **Routing:** input 0 holds words 0x001, 0x101, 0x201, 0x301 → push_out one-hot 0001, 0010, 0100, 1000 on consecutive cycles, data_out equal to each word, contador0..3 each =1.
- **Priority and skipping:** inputs 0 and 2 are both non-empty and output 1 is almost full; input 0 head 0x101, input 2 head 0x001 → pop_in=0100 and the word goes to output 0. Deassert almost_full_out[1] → pop_in=0001 next.
- **Fill to almost-full:** Umbral_alto=6, each output FIFO depth 8, input 0 holds 8 words of class 2 → pops continue until almost_full_out[2] rises, then at most 1 further push. pop_in stays 0 while input 0's only head word is blocked.
- **Init mid-stream:** assert init while ACTIVE → pop_in=0 the same cycle, and the last push completes the next cycle. New thresholds are taken, then init=0 resumes from IDLE.
- **Reset mid-stream:** reset=0 during back-to-back pushes → the next edge clears push_out, data_out, contador0..3 and thresholds to 0, and estado=0.
